// File: rtl/mem_ctrl.sv
// Byte-serial memory responder: arbitrates IF fetches and MEM loads/stores onto a
// synchronous byte RAM and returns assembled little-endian words with a done pulse.
module mem_ctrl #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [31:0]           if_addr_i,
  input  logic                  if_flush_i,
  output logic                  if_done_o,
  output logic [31:0]           if_inst_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [2:0]            mem_len_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic                  mem_done_o,
  output logic [31:0]           mem_rdata_o,
  output logic                  mem_busy_o,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t                state, state_n;
  logic [1:0]            issue, issue_n;
  logic [1:0]            cap, cap_n;
  logic                  cap_live, cap_live_n;
  logic [1:0]            last, last_n;
  logic [RAM_ADDR_W-1:0] base, base_n;
  logic [31:0]           wdata, wdata_n;
  logic [31:0]           asm_q, asm_n, asm_merge;
  logic [RAM_ADDR_W-1:0] ram_addr_n;
  logic                  ram_wr_n;
  logic [7:0]            ram_dout_n;
  logic [31:0]           if_inst_n, mem_rdata_n;
  logic                  if_done_n, mem_done_n, busy_n;
  logic [1:0]            len_last;

  // Address bits above the RAM window are dropped by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr_i[31:RAM_ADDR_W], mem_addr_i[31:RAM_ADDR_W]};

  always_comb begin
    case (mem_len_i)
      3'd1:    len_last = 2'd0;
      3'd2:    len_last = 2'd1;
      default: len_last = 2'd3;
    endcase
  end

  always_comb begin
    state_n     = state;
    issue_n     = issue;
    cap_n       = cap;
    cap_live_n  = cap_live;
    last_n      = last;
    base_n      = base;
    wdata_n     = wdata;
    asm_n       = asm_q;
    ram_addr_n  = ram_addr_o;
    ram_wr_n    = 1'b0;
    ram_dout_n  = ram_dout_o;
    if_inst_n   = if_inst_o;
    mem_rdata_n = mem_rdata_o;
    if_done_n   = 1'b0;
    mem_done_n  = 1'b0;
    asm_merge   = asm_q | (32'(ram_din_i) << {cap, 3'b000});

    case (state)
      IDLE: begin
        // No accept while a done pulse is showing: the requester is still dropping its req.
        if (!if_done_o && !mem_done_o) begin
          if (mem_req_i) begin
            base_n     = mem_addr_i[RAM_ADDR_W-1:0];
            ram_addr_n = mem_addr_i[RAM_ADDR_W-1:0];
            last_n     = len_last;
            issue_n    = '0;
            cap_n      = '0;
            cap_live_n = 1'b0;
            asm_n      = '0;
            wdata_n    = mem_wdata_i;
            if (mem_we_i) begin
              state_n    = MEM_WR;
              ram_wr_n   = 1'b1;
              ram_dout_n = mem_wdata_i[7:0];
            end else begin
              state_n = MEM_RD;
            end
          end else if (if_req_i && !if_flush_i) begin
            base_n     = if_addr_i[RAM_ADDR_W-1:0];
            ram_addr_n = if_addr_i[RAM_ADDR_W-1:0];
            last_n     = 2'd3;
            issue_n    = '0;
            cap_n      = '0;
            cap_live_n = 1'b0;
            asm_n      = '0;
            state_n    = IF_RD;
          end
        end
      end

      MEM_WR: begin
        if (issue == last) begin
          state_n    = IDLE;
          mem_done_n = 1'b1;
        end else begin
          issue_n    = issue + 2'd1;
          ram_addr_n = base + RAM_ADDR_W'(issue_n);
          ram_dout_n = wdata[{issue_n, 3'b000} +: 8];
          ram_wr_n   = 1'b1;
        end
      end

      IF_RD, MEM_RD: begin
        if (state == IF_RD && if_flush_i) begin
          state_n = IDLE;
        end else begin
          if (issue != last) begin
            issue_n    = issue + 2'd1;
            ram_addr_n = base + RAM_ADDR_W'(issue_n);
          end
          // Capture trails issue by two edges: one for the address, one for RAM latency.
          cap_live_n = 1'b1;
          if (cap_live) begin
            if (cap == last) begin
              state_n = IDLE;
              if (state == IF_RD) begin
                if_inst_n = asm_merge;
                if_done_n = 1'b1;
              end else begin
                mem_rdata_n = asm_merge;
                mem_done_n  = 1'b1;
              end
            end else begin
              cap_n = cap + 2'd1;
              asm_n = asm_merge;
            end
          end
        end
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      issue       <= '0;
      cap         <= '0;
      cap_live    <= 1'b0;
      last        <= '0;
      base        <= '0;
      wdata       <= '0;
      asm_q       <= '0;
      ram_addr_o  <= '0;
      ram_wr_o    <= 1'b0;
      ram_dout_o  <= '0;
      if_inst_o   <= '0;
      mem_rdata_o <= '0;
      if_done_o   <= 1'b0;
      mem_done_o  <= 1'b0;
      mem_busy_o  <= 1'b0;
    end else begin
      state       <= state_n;
      issue       <= issue_n;
      cap         <= cap_n;
      cap_live    <= cap_live_n;
      last        <= last_n;
      base        <= base_n;
      wdata       <= wdata_n;
      asm_q       <= asm_n;
      ram_addr_o  <= ram_addr_n;
      ram_wr_o    <= ram_wr_n;
      ram_dout_o  <= ram_dout_n;
      if_inst_o   <= if_inst_n;
      mem_rdata_o <= mem_rdata_n;
      if_done_o   <= if_done_n;
      mem_done_o  <= mem_done_n;
      mem_busy_o  <= busy_n;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: synchronous byte RAM model plus a reference byte store that
// predicts read data and per-cycle RAM port activity.
module tb_mem_ctrl;
  localparam int          AW    = 17;
  localparam logic [31:0] AMASK = 32'h0001_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic          if_flush = 1'b0;
  logic          if_done;
  logic [31:0]   if_inst;
  logic          mem_req = 1'b0;
  logic          mem_we = 1'b0;
  logic [2:0]    mem_len = 3'd0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic          mem_done;
  logic [31:0]   mem_rdata;
  logic          mem_busy;
  logic [AW-1:0] ram_addr;
  logic          ram_wr;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din = '0;

  int total = 0;
  int bad = 0;
  logic [31:0] last_inst = '0;
  logic [31:0] last_rdata = '0;

  logic [7:0] ram   [0:(1<<AW)-1];
  bit         wrote [0:(1<<AW)-1];
  logic [7:0] ref_mem [int];

  mem_ctrl #(.RAM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_done_o(if_done), .if_inst_o(if_inst),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len),
    .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_done_o(mem_done), .mem_rdata_o(mem_rdata), .mem_busy_o(mem_busy),
    .ram_addr_o(ram_addr), .ram_wr_o(ram_wr), .ram_dout_o(ram_dout),
    .ram_din_i(ram_din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a * 37 + (a >>> 8) * 11 + 5);
  endfunction

  // Synchronous RAM: data for the address seen at an edge appears after that edge.
  always @(posedge clk) begin
    ram_din <= wrote[int'(ram_addr)] ? ram[int'(ram_addr)] : init_byte(int'(ram_addr));
    if (ram_wr) begin
      ram[int'(ram_addr)]   <= ram_dout;
      wrote[int'(ram_addr)] <= 1'b1;
    end
  end

  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = ref_rd(int'((a + 32'(i)) & AMASK));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_mem(input logic we, input logic [2:0] len, input logic [31:0] addr,
                         input logic [31:0] wd);
    int n;
    int last_j;
    logic [31:0] exp_rd;
    n = (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
    last_j = we ? n : n + 1;
    exp_rd = ref_read(addr, n);
    mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd;
    for (int j = 0; j <= last_j; j++) begin
      @(posedge clk); #1;
      chk("if_done_quiet", 32'(if_done), 32'd0);
      if (we) begin
        if (j < n) begin
          chk("wr_strobe", 32'(ram_wr), 32'd1);
          chk("wr_addr", 32'(ram_addr), (addr + 32'(j)) & AMASK);
          chk("wr_byte", 32'(ram_dout), 32'(wd[8*j +: 8]));
          chk("wr_done_early", 32'(mem_done), 32'd0);
          chk("wr_busy", 32'(mem_busy), 32'd1);
        end else begin
          chk("wr_strobe_end", 32'(ram_wr), 32'd0);
          chk("wr_done", 32'(mem_done), 32'd1);
          chk("wr_idle", 32'(mem_busy), 32'd0);
        end
      end else begin
        chk("rd_addr", 32'(ram_addr), (addr + 32'((j < n) ? j : n - 1)) & AMASK);
        chk("rd_no_wr", 32'(ram_wr), 32'd0);
        if (j < last_j) begin
          chk("rd_done_early", 32'(mem_done), 32'd0);
          chk("rd_busy", 32'(mem_busy), 32'd1);
        end else begin
          chk("rd_done", 32'(mem_done), 32'd1);
          chk("rd_data", mem_rdata, exp_rd);
          chk("rd_idle", 32'(mem_busy), 32'd0);
          last_rdata = exp_rd;
        end
      end
    end
    if (we) for (int i = 0; i < n; i++) ref_mem[int'((addr + 32'(i)) & AMASK)] = wd[8*i +: 8];
    mem_req = 1'b0;
    @(posedge clk); #1;
    chk("mem_done_pulse", 32'(mem_done), 32'd0);
    chk("no_accept_on_done", 32'(mem_busy), 32'd0);
    if (!we) chk("rdata_hold", mem_rdata, last_rdata);
  endtask

  task automatic run_if(input logic [31:0] addr);
    logic [31:0] exp_inst;
    exp_inst = ref_read(addr, 4);
    if_req = 1'b1; if_addr = addr;
    for (int j = 0; j <= 5; j++) begin
      @(posedge clk); #1;
      chk("if_addr", 32'(ram_addr), (addr + 32'((j < 4) ? j : 3)) & AMASK);
      chk("if_no_wr", 32'(ram_wr), 32'd0);
      chk("if_mem_quiet", 32'(mem_done), 32'd0);
      if (j < 5) begin
        chk("if_done_early", 32'(if_done), 32'd0);
        chk("if_inst_hold", if_inst, last_inst);
      end else begin
        chk("if_done", 32'(if_done), 32'd1);
        chk("if_inst", if_inst, exp_inst);
        last_inst = exp_inst;
      end
    end
    if_req = 1'b0;
    @(posedge clk); #1;
    chk("if_done_pulse", 32'(if_done), 32'd0);
    chk("if_inst_keep", if_inst, last_inst);
    chk("if_rdata_untouched", mem_rdata, last_rdata);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_if_done", 32'(if_done), 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_mem_done", 32'(mem_done), 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_busy", 32'(mem_busy), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wr", 32'(ram_wr), 32'd0);
    chk("rst_ram_dout", 32'(ram_dout), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Instruction image then fetch.
    run_mem(1'b1, 3'd4, 32'h0000_0100, 32'h0010_0513);
    run_if(32'h0000_0100);
    chk("tp_inst", if_inst, 32'h0010_0513);

    // Halfword store wrapping past the top of RAM, read back.
    run_mem(1'b1, 3'd2, 32'h0001_FFFF, 32'hAABB_CCDD);
    run_mem(1'b0, 3'd2, 32'h0001_FFFF, 32'h0);
    chk("tp_wrap_read", mem_rdata, 32'h0000_CCDD);

    // Simultaneous requests: MEM wins, IF waits out the done cycle.
    run_mem(1'b1, 3'd1, 32'h0000_0020, 32'h0000_0080);
    if_req = 1'b1; if_addr = 32'h0000_0100;
    run_mem(1'b0, 3'd1, 32'h0000_0020, 32'h0);
    chk("tp_arb_rdata", mem_rdata, 32'h0000_0080);
    run_if(32'h0000_0100);

    // Flush in IDLE blocks the same-edge accept.
    if_req = 1'b1; if_addr = 32'h0000_0200; if_flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_idle_block", 32'(mem_busy), 32'd0);
    if_flush = 1'b0;
    run_if(32'h0000_0200);

    // Flush on the third edge after accept, then refetch elsewhere.
    if_req = 1'b1; if_addr = 32'h0000_0300;
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      chk("flush_pre_done", 32'(if_done), 32'd0);
      chk("flush_pre_busy", 32'(mem_busy), 32'd1);
    end
    if_flush = 1'b1; if_addr = 32'h0000_0100;
    @(posedge clk); #1;
    chk("flush_idle", 32'(mem_busy), 32'd0);
    chk("flush_no_done", 32'(if_done), 32'd0);
    chk("flush_inst_keep", if_inst, last_inst);
    if_flush = 1'b0;
    run_if(32'h0000_0100);

    // Length code 3 behaves as a full word.
    run_mem(1'b0, 3'd3, 32'h0000_0100, 32'h0);
    chk("tp_len3", mem_rdata, 32'h0010_0513);

    // Reset during a store.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 3'd4;
    mem_addr = 32'h0000_0400; mem_wdata = 32'h1122_3344;
    @(posedge clk); #1;
    chk("rst_mid_wr0", 32'(ram_wr), 32'd1);
    @(posedge clk); #1;
    chk("rst_mid_addr1", 32'(ram_addr), 32'h401);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_wr", 32'(ram_wr), 32'd0);
    chk("rst_mid_busy", 32'(mem_busy), 32'd0);
    chk("rst_mid_done", 32'(mem_done), 32'd0);
    chk("rst_mid_rdata", mem_rdata, 32'd0);
    chk("rst_mid_inst", if_inst, 32'd0);
    mem_req = 1'b0;
    ref_mem[32'h400] = 8'h44;
    ref_mem[32'h401] = 8'h33;
    last_inst = '0;
    last_rdata = '0;
    @(posedge clk); #1;
    chk("rst_mid_no_done", 32'(mem_done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_mem(1'b0, 3'd4, 32'h0000_0400, 32'h0);

    // Random traffic in a small window straddling the RAM top, with junk upper bits.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int kind;
      kind = int'($urandom_range(0, 2));
      a = ($urandom & 32'hFFFE_0000) | ((32'h0001_FFF0 + 32'($urandom_range(0, 31))) & AMASK);
      case (kind)
        0:       run_if(a);
        1:       run_mem(1'b0, 3'($urandom_range(0, 7)), a, 32'h0);
        default: run_mem(1'b1, 3'($urandom_range(0, 7)), a, $urandom);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
